// File: rtl/wb_result_collector_pkg.sv
// Shared types for the writeback result collector: exception record, per-source
// payload, FU index assignment and default sizing.
package wb_result_collector_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned XLEN          = 64;

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_BRANCH = 3'd1,
    FU_CSR    = 3'd2,
    FU_MULT   = 3'd3,
    FU_LOAD   = 3'd4,
    FU_STORE  = 3'd5
  } fu_idx_e;

  localparam int unsigned NR_FU_DEFAULT       = int'(FU_STORE) + 1;
  localparam int unsigned NR_WB_PORTS_DEFAULT = 4;
  localparam int unsigned FIFO_DEPTH_DEFAULT  = 2;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          wbdata;
    exception_t               ex;
  } wb_payload_t;

  // Next round-robin index after idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_result_collector_src_fifo.sv
// Per-source result FIFO: power-of-two depth, registered occupancy, flush and
// synchronous reset empty it without touching the storage array.
module wb_result_collector_src_fifo
  import wb_result_collector_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  wb_payload_t data_i,
  output wb_payload_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_payload_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_result_collector.sv
// Collects FU results through per-source FIFOs and packs up to NR_WB_PORTS of
// them per cycle onto the registered scoreboard writeback bus, round-robin.
module wb_result_collector
  import wb_result_collector_pkg::*;
#(
  parameter int unsigned NR_FU       = NR_FU_DEFAULT,
  parameter int unsigned NR_WB_PORTS = NR_WB_PORTS_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEFAULT
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  logic [NR_FU-1:0]                          fu_valid_i,
  output logic [NR_FU-1:0]                          fu_ready_o,
  input  logic [NR_FU-1:0][TRANS_ID_BITS-1:0]       fu_trans_id_i,
  input  logic [NR_FU-1:0][XLEN-1:0]                fu_wbdata_i,
  input  exception_t [NR_FU-1:0]                    fu_ex_i,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wbdata_o,
  output exception_t [NR_WB_PORTS-1:0]              ex_o,
  output logic [NR_WB_PORTS-1:0]                    wt_valid_o,
  output logic                                      pending_o
);

  localparam int unsigned SRC_W  = (NR_FU > 1) ? $clog2(NR_FU) : 1;
  localparam int unsigned PORT_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  if (NR_WB_PORTS > NR_FU) begin : g_bad_cfg
    $error("wb_result_collector: NR_WB_PORTS must not exceed NR_FU");
  end

  logic [NR_FU-1:0]       full, empty, push, grant;
  wb_payload_t            head [NR_FU];
  logic [SRC_W-1:0]       rr_q, rr_d;
  logic [NR_WB_PORTS-1:0] port_vld, wt_valid_q;
  wb_payload_t            port_pl [NR_WB_PORTS];
  wb_payload_t            out_q   [NR_WB_PORTS];

  // Readiness comes only from registered occupancy; a popped full FIFO still stalls.
  assign fu_ready_o = ~full & {NR_FU{!rst_i}};
  assign push       = fu_valid_i & fu_ready_o;

  for (genvar i = 0; i < NR_FU; i++) begin : g_src
    wb_payload_t in_pl;
    assign in_pl = {fu_trans_id_i[i], fu_wbdata_i[i], fu_ex_i[i]};

    wb_result_collector_src_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .pop_i   (grant[i]),
      .data_i  (in_pl),
      .head_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Scan from rr_q, packing granted heads onto ports 0.. with no gaps.
  always_comb begin
    int unsigned idx;
    int unsigned nk;
    grant    = '0;
    port_vld = '0;
    port_pl  = '{default: '0};
    rr_d     = rr_q;
    idx      = 0;
    nk       = 0;
    for (int unsigned j = 0; j < NR_FU; j++) begin
      idx = (32'(rr_q) + j) % NR_FU;
      if (!empty[SRC_W'(idx)] && nk < NR_WB_PORTS) begin
        grant[SRC_W'(idx)]     = 1'b1;
        port_vld[PORT_W'(nk)]  = 1'b1;
        port_pl[PORT_W'(nk)]   = head[SRC_W'(idx)];
        rr_d                   = SRC_W'(wrap_inc(idx, NR_FU));
        nk++;
      end
    end
  end

  // Grants made in a flush cycle are dropped and do not move the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      wt_valid_q <= '0;
    end else if (flush_i) begin
      wt_valid_q <= '0;
    end else begin
      rr_q       <= rr_d;
      wt_valid_q <= port_vld;
    end
  end

  for (genvar k = 0; k < NR_WB_PORTS; k++) begin : g_port
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        out_q[k] <= '0;
      end else if (!flush_i && port_vld[k]) begin
        out_q[k] <= port_pl[k];
      end
    end

    assign trans_id_o[k] = out_q[k].trans_id;
    assign wbdata_o[k]   = out_q[k].wbdata;
    assign ex_o[k]       = out_q[k].ex;
  end

  assign wt_valid_o = wt_valid_q;
  assign pending_o  = (|(~empty)) || (|wt_valid_q);

endmodule

// File: tb/tb_wb_result_collector.sv
// Directed bench for wb_result_collector: single-result table plus hand-built
// contention, fairness, backpressure, flush and mid-stream reset sequences.
module tb_wb_result_collector;
  import wb_result_collector_pkg::*;

  localparam int NF = 6;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [NF-1:0]                    fu_valid;
  logic [NF-1:0]                    fu_ready;
  logic [NF-1:0][TRANS_ID_BITS-1:0] fu_tid;
  logic [NF-1:0][XLEN-1:0]          fu_data;
  exception_t [NF-1:0]              fu_ex;
  logic [NP-1:0][TRANS_ID_BITS-1:0] tid_o;
  logic [NP-1:0][XLEN-1:0]          data_o;
  exception_t [NP-1:0]              ex_o;
  logic [NP-1:0]                    vld_o;
  logic                             pend;

  int nchk = 0;
  int nerr = 0;

  wb_result_collector #(
    .NR_FU       (NF),
    .NR_WB_PORTS (NP),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .fu_valid_i    (fu_valid),
    .fu_ready_o    (fu_ready),
    .fu_trans_id_i (fu_tid),
    .fu_wbdata_i   (fu_data),
    .fu_ex_i       (fu_ex),
    .trans_id_o    (tid_o),
    .wbdata_o      (data_o),
    .ex_o          (ex_o),
    .wt_valid_o    (vld_o),
    .pending_o     (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [2:0] tid;
    logic [63:0] data;
    exception_t ex;
    logic [3:0] exp_vld;
    logic [2:0] exp_tid;
    logic [63:0] exp_data;
    exception_t exp_ex;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    fu_valid = '0;
    fu_tid   = '0;
    fu_data  = '0;
    fu_ex    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_tags();
    for (int i = 0; i < NF; i++) begin
      fu_tid[i]  = 3'(i);
      fu_data[i] = {8'(i), 56'd0};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int gcnt [NF];
    int glast [NF];
    int gmax [NF];
    int s;
    int acc;
    logic will;
    logic [2:0] bp_tid [3];
    logic [2:0] q1 [$];
    logic [2:0] tmp;

    vecs[0] = '{src: 2, tid: 3'd5, data: 64'hDEAD, ex: '0,
                exp_vld: 4'b0001, exp_tid: 3'd5, exp_data: 64'hDEAD, exp_ex: '0};
    vecs[1] = '{src: 0, tid: 3'd1, data: 64'h0123_4567_89AB_CDEF, ex: '0,
                exp_vld: 4'b0001, exp_tid: 3'd1, exp_data: 64'h0123_4567_89AB_CDEF, exp_ex: '0};
    vecs[2] = '{src: 5, tid: 3'd7, data: 64'h0,
                ex: '{cause: 64'd2, tval: 64'h8000_0000, valid: 1'b1},
                exp_vld: 4'b0001, exp_tid: 3'd7, exp_data: 64'h0,
                exp_ex: '{cause: 64'd2, tval: 64'h8000_0000, valid: 1'b1}};
    vecs[3] = '{src: 3, tid: 3'd0, data: 64'hFFFF_FFFF_FFFF_FFFF, ex: '0,
                exp_vld: 4'b0001, exp_tid: 3'd0, exp_data: 64'hFFFF_FFFF_FFFF_FFFF, exp_ex: '0};

    // Reset state.
    clr();
    tick();
    chk("rst_vld", vld_o, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ready", fu_ready, 0);
    chk("rst_tid", tid_o, 0);
    chk("rst_data", data_o, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", fu_ready, 6'h3f);

    // Single results through an idle collector.
    for (int v = 0; v < 4; v++) begin
      clr();
      fu_valid[vecs[v].src] = 1'b1;
      fu_tid[vecs[v].src]   = vecs[v].tid;
      fu_data[vecs[v].src]  = vecs[v].data;
      fu_ex[vecs[v].src]    = vecs[v].ex;
      tick();
      clr();
      chk("single_mid_vld", vld_o, 0);
      chk("single_mid_pend", pend, 1);
      tick();
      chk("single_vld", vld_o, vecs[v].exp_vld);
      chk("single_tid", tid_o[0], vecs[v].exp_tid);
      chk("single_data", data_o[0], vecs[v].exp_data);
      chk("single_ex", ex_o[0], vecs[v].exp_ex);
      tick();
      chk("single_after_vld", vld_o, 0);
      chk("single_after_pend", pend, 0);
    end

    // Contention: all six in one cycle from rr_ptr=0.
    do_reset();
    for (int i = 0; i < NF; i++) begin
      fu_tid[i]  = 3'(i);
      fu_data[i] = 64'h100 + 64'(i);
    end
    fu_valid = '1;
    tick();
    clr();
    chk("cont_mid_vld", vld_o, 0);
    tick();
    chk("cont1_vld", vld_o, 4'hf);
    chk("cont1_tid", tid_o, {3'd3, 3'd2, 3'd1, 3'd0});
    chk("cont1_data0", data_o[0], 64'h100);
    chk("cont1_data3", data_o[3], 64'h103);
    tick();
    chk("cont2_vld", vld_o, 4'b0011);
    chk("cont2_tid0", tid_o[0], 3'd4);
    chk("cont2_tid1", tid_o[1], 3'd5);
    tick();
    chk("cont3_vld", vld_o, 0);
    chk("cont3_pend", pend, 0);
    fu_valid[0] = 1'b1; fu_tid[0] = 3'd6;
    fu_valid[3] = 1'b1; fu_tid[3] = 3'd7;
    tick();
    clr();
    tick();
    chk("cont_rr_vld", vld_o, 4'b0011);
    chk("cont_rr_tid0", tid_o[0], 3'd6);
    chk("cont_rr_tid1", tid_o[1], 3'd7);

    // Fairness: all sources saturating, observe 12 output cycles.
    do_reset();
    load_tags();
    fu_valid = '1;
    for (int i = 0; i < NF; i++) begin
      gcnt[i] = 0; glast[i] = -1; gmax[i] = 0;
    end
    for (int n = 1; n <= 13; n++) begin
      tick();
      if (n >= 2) begin
        for (int k = 0; k < NP; k++) begin
          if (vld_o[k]) begin
            s = int'(data_o[k][63:56]);
            if (s >= 0 && s < NF) begin
              gcnt[s]++;
              if (glast[s] >= 0 && n - glast[s] > gmax[s]) gmax[s] = n - glast[s];
              glast[s] = n;
            end
          end
        end
      end
    end
    for (int i = 0; i < NF; i++) begin
      chk($sformatf("fair_cnt_src%0d(count=%0d)", i, gcnt[i]), (gcnt[i] >= 7 && gcnt[i] <= 9), 1);
      chk($sformatf("fair_gap_src%0d(gap=%0d)", i, gmax[i]), (gmax[i] >= 1 && gmax[i] <= 2), 1);
    end
    clr();
    for (int n = 0; n < 6; n++) tick();

    // Backpressure: source 1 pushes three results against saturating neighbours.
    do_reset();
    load_tags();
    fu_valid = 6'b111101;
    bp_tid[0] = 3'd6; bp_tid[1] = 3'd2; bp_tid[2] = 3'd4;
    acc = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n >= 4 && acc < 3) begin
        fu_valid[1] = 1'b1;
        fu_tid[1]   = bp_tid[acc];
        fu_data[1]  = {8'd1, 56'(acc)};
      end else begin
        fu_valid[1] = 1'b0;
      end
      will = fu_valid[1] && fu_ready[1];
      tick();
      if (will) begin
        acc++;
        if (acc == 2) chk("bp_ready_drop", fu_ready[1], 0);
      end
      for (int k = 0; k < NP; k++)
        if (vld_o[k] && data_o[k][63:56] == 8'd1) q1.push_back(tid_o[k]);
    end
    chk("bp_accepts", acc, 3);
    chk("bp_out_count", q1.size(), 3);
    for (int i = 0; i < 3; i++) begin
      tmp = (q1.size() > i) ? q1[i] : 3'bxxx;
      chk($sformatf("bp_order%0d", i), tmp, bp_tid[i]);
    end
    clr();
    for (int n = 0; n < 6; n++) tick();

    // Flush with five buffered results and a push in the flush cycle.
    load_tags();
    fu_valid = 6'b011111;
    tick();
    clr();
    flush = 1'b1;
    fu_valid[5] = 1'b1; fu_tid[5] = 3'd7;
    fu_valid[0] = 1'b1; fu_tid[0] = 3'd6;
    chk("flush_cycle_ready", fu_ready, 6'h3f);
    chk("flush_cycle_pend", pend, 1);
    tick();
    flush = 1'b0;
    clr();
    chk("flush_vld", vld_o, 0);
    chk("flush_pend", pend, 0);
    chk("flush_ready", fu_ready, 6'h3f);
    tick();
    chk("flush_after1_vld", vld_o, 0);
    tick();
    chk("flush_after2_vld", vld_o, 0);
    chk("flush_after2_pend", pend, 0);

    // Reset in the middle of traffic.
    load_tags();
    fu_valid = '1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_vld", vld_o, 0);
    chk("mrst_tid", tid_o, 0);
    chk("mrst_data", data_o, 0);
    chk("mrst_ex", {ex_o[3], ex_o[2], ex_o[1], ex_o[0]}, 0);
    chk("mrst_pend", pend, 0);
    chk("mrst_ready", fu_ready, 0);
    rst = 1'b0;
    clr();
    tick();
    chk("mrst_after_vld", vld_o, 0);
    chk("mrst_after_tid", tid_o, 0);
    chk("mrst_after_data", data_o, 0);
    chk("mrst_after_pend", pend, 0);
    chk("mrst_after_ready", fu_ready, 6'h3f);
    fu_valid[0] = 1'b1; fu_tid[0] = 3'd1;
    fu_valid[4] = 1'b1; fu_tid[4] = 3'd2;
    tick();
    clr();
    tick();
    chk("mrst_push_vld", vld_o, 4'b0011);
    chk("mrst_push_tid0", tid_o[0], 3'd1);
    chk("mrst_push_tid1", tid_o[1], 3'd2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/wb_result_collector.md
Name: wb_result_collector

Overview:
- Functional-unit side of the scoreboard writeback interface. Results come from NR_FU functional units (ALU, branch, CSR, mult, LSU load, LSU store, and others) on independent valid/ready handshakes.
- Each source has its own small FIFO.
- The block drives the registered writeback bus: trans_id, wbdata, exception and valid per port, NR_WB_PORTS ports.
- Sits between the execute-stage FUs and the issue stage's writeback inputs, and replaces fixed per-FU port wiring.

Parameters:
- NR_FU, 6, number of result sources.
- NR_WB_PORTS, 4, number of scoreboard writeback ports; must be ≤ NR_FU.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, ≥ 2.
- TRANS_ID_BITS, 3, scoreboard transaction-id width.
- XLEN, 64, result data width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  pipeline flush; drop all buffered results.
- fu_valid_i  in  NR_FU  result valid per source.
- fu_ready_o  out  NR_FU  source FIFO not full.
- fu_trans_id_i  in  NR_FU×TRANS_ID_BITS  transaction id per source.
- fu_wbdata_i  in  NR_FU×XLEN  result data per source.
- fu_ex_i  in  NR_FU×exception_t  exception per source (cause, tval, valid).
- trans_id_o  out  NR_WB_PORTS×TRANS_ID_BITS  writeback transaction id.
- wbdata_o  out  NR_WB_PORTS×XLEN  writeback data.
- ex_o  out  NR_WB_PORTS×exception_t  writeback exception.
- wt_valid_o  out  NR_WB_PORTS  writeback valid per port.
- pending_o  out  1  any FIFO non-empty or any wt_valid_o set.

Behaviour:
- Reset, synchronous with rst_i=1:
  - All FIFOs empty; rr_ptr=0.
  - wt_valid_o=0; trans_id_o, wbdata_o and ex_o all zero.
  - fu_ready_o all 1 from the first cycle after reset. During reset, fu_ready_o=0.
  - pending_o=0.
- Push:
  - A source is pushed on the clock edge where fu_valid_i[i] && fu_ready_o[i].
  - fu_ready_o[i] = !full[i], derived only from registered occupancy. There is no pop-through: a full FIFO stays not-ready even in a cycle where it is popped.
- Arbitration, combinational, each cycle:
  - Scan sources starting at rr_ptr, wrapping modulo NR_FU.
  - Grant up to NR_WB_PORTS non-empty FIFOs.
  - The k-th granted source drives port k; ports fill from 0 upward with no gaps.
  - Each granted FIFO pops its head.
- Output register:
  - Port k captures trans_id, wbdata and ex from its granted head; wt_valid_o[k]=1.
  - Unused ports get wt_valid_o=0, and their data fields are held (no zeroing required).
  - Outputs are valid for exactly one cycle per result. The scoreboard has no backpressure.
- rr_ptr update:
  - After a cycle with ≥1 grant, rr_ptr = (last granted source index + 1) mod NR_FU.
  - With no grant, rr_ptr is unchanged.
  - Guarantees starvation freedom: any non-empty source is granted within ceil(NR_FU/NR_WB_PORTS) cycles.
- Latency:
  - A push on edge t, with an uncontended port, appears on wt_valid_o during cycle t+2 (the FIFO registers it, then the output registers it).
  - At most one result per source per cycle; FIFO order is preserved per source.
- Flush (flush_i=1):
  - On that edge all FIFOs are emptied, wt_valid_o is cleared, and rr_ptr is kept.
  - Pushes and grants in the flush cycle are discarded.
  - fu_ready_o in the flush cycle follows normal occupancy; the handshake completes but the data is dropped.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged, and the pointers both advance with wrap at FIFO_DEPTH.
- Reset mid-stream: identical to the reset state above; all in-flight results are lost.
- pending_o: combinational OR of all FIFO non-empty flags and wt_valid_o. Used by the controller to detect quiescence before fence or flush completion.

Decomposition:
- Package (ariane_pkg / RISA_PKG): exception_t, TRANS_ID_BITS, XLEN, and a localparam for the FU index assignment (FU_ALU=0 … FU_STORE=5).
- Sub-module wb_src_fifo:
  - Parameterised depth, holding the {trans_id, wbdata, ex} payload.
  - Interface: push/pop/full/empty/head, flush input, synchronous active-high reset.
  - Instantiated NR_FU times.
- The top level contains the arbiter, rr_ptr and the output registers.

Test Plan:
- Single result: source 2 pushes trans_id=5, wbdata=0xDEAD. Required: wt_valid_o=4'b0001 two cycles later, port 0 carries trans_id 5 and 0xDEAD, one-cycle pulse; pending_o falls afterwards.
- Contention: all 6 sources push in the same cycle with rr_ptr=0. Required:
  - Next-but-one cycle: sources 0–3 on ports 0–3.
  - Following cycle: sources 4 and 5 on ports 0 and 1, wt_valid_o=4'b0011.
  - rr_ptr ends at 0.
- Backpressure: source 1 pushes 3 results back-to-back with FIFO_DEPTH=2 and sources 0 and 2–5 saturating. Required: fu_ready_o[1] drops after 2 accepts, and all 3 results emerge in push order with their trans_ids.
- Fairness: sources 0–5 continuously valid for 12 cycles. Required: each source is granted 8 times ±1, and no source waits more than 2 cycles between grants.
- Flush: 5 results are buffered and flush_i is asserted for 1 cycle. Required: the next cycle shows wt_valid_o=0, pending_o=0 and all fu_ready_o=1; a push in the flush cycle never appears.
- Reset mid-operation: rst_i is asserted while FIFOs are half full. Required: all outputs zero during the reset cycle and the one after, and the first post-reset push yields port 0 with source-0 priority (rr_ptr=0).
